// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Optional two's-complement mode (op_signed port) enabled by defining SEQ_MULT_SIGNED_EN.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               op_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2*WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic             sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SEQ_MULT_SIGNED_EN
  assign sgn = op_signed;
`else
  assign sgn = 1'b0;
`endif

  // Signed mode multiplies magnitudes; the most-negative value's magnitude
  // still fits in WIDTH bits when read as unsigned.
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? WIDTH'(-a) : a;
  assign b_mag = b_neg ? WIDTH'(-b) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a_mag;
            b_reg <= b_mag;
            neg   <= a_neg ^ b_neg;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (b_reg[0])
            acc <= acc + ({{(WIDTH+1){1'b0}}, a_reg} << cnt);
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1))
            state <= S_FIN;
        end
        S_FIN: begin
          // Carry bit of acc is provably zero; the cast drops it.
          p     <= (2*WIDTH)'(neg ? -acc : acc);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: driver pushes expected products, a negedge monitor checks them.
module tb_seq_multiplier;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0, b = '0;
  logic           op_signed = 1'b0;
  logic           busy, done;
  logic [2*W-1:0] p;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [2*W-1:0] exp;
    int             acc;
  } exp_t;
  exp_t q[$];
  logic [2*W-1:0] last_p = '0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SEQ_MULT_SIGNED_EN
    .op_signed(op_signed),
`endif
    .busy(busy), .done(done), .p(p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as the mode defines them.
  function automatic logic [2*W-1:0] ref_mul(input int ai, input int bi, input bit s);
    int x, y, pr;
    x = ai;
    y = bi;
    if (s && ai >= 2**(W-1)) x = ai - 2**W;
    if (s && bi >= 2**(W-1)) y = bi - 2**W;
    pr = x * y;
    return (2*W)'(pr);
  endfunction

  // Called just after a negedge; start is sampled on the following posedge.
  task automatic issue(input int ai, input int bi, input bit s);
    exp_t e;
    a = W'(ai);
    b = W'(bi);
    op_signed = s;
    start = 1'b1;
    e.exp = ref_mul(ai, bi, s);
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op_signed = 1'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      check("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_p = '0;
    end else if (done) begin
      if (q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t f;
        f = q.pop_front();
        check("done_latency", cyc, f.acc + W + 1);
        check("product", p, f.exp);
        check("busy_at_done", busy, 0);
      end
      last_p = p;
    end else begin
      check("p_hold", p, last_p);
      if (q.size() > 0) begin
        if (cyc > q[0].acc && cyc <= q[0].acc + W)
          check("busy_run", busy, 1);
      end else begin
        check("busy_idle", busy, 0);
      end
    end
  end

  initial begin
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p", p, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;

    issue(15, 15, 0);
    wait_idle();
    issue(0, 9, 0);
    wait_idle();
    issue(9, 0, 0);
    wait_idle();

    // Start pulsed mid-RUN must be ignored.
    issue(11, 5, 0);
    @(negedge clk);
    #1;
    a = 4'd3;
    b = 4'd2;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Asynchronous abort two cycles into RUN.
    issue(13, 7, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_p", p, 0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    issue(3, 5, 0);
    wait_idle();

    // Back-to-back: second start raised in the cycle done is seen.
    issue(7, 6, 0);
    wait_idle();
    issue(13, 11, 0);
    wait_idle();

`ifdef SEQ_MULT_SIGNED_EN
    issue(8, 8, 1);
    wait_idle();
    issue(8, 7, 1);
    wait_idle();
    issue(5, 13, 1);
    wait_idle();
    issue(8, 8, 0);
    wait_idle();
`endif

    for (int i = 0; i < 40; i++) begin
      int gap;
      bit s;
`ifdef SEQ_MULT_SIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      issue(int'($urandom_range(0, 2**W - 1)), int'($urandom_range(0, 2**W - 1)), s);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
      end
      wait_idle();
      gap = int'($urandom_range(0, 3));
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        #1;
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
